// File: rtl/peridot_config_proc_mb.sv
// peridot_config_proc_mb: configuration-layer protocol engine between the host
// byte stream and the packet layer. It strips escape sequences and multi-byte
// config commands from the host stream, commits each command atomically, and
// answers it with a status response. A stalled command is dropped on timeout.
//
// Optional feature macro: PERIDOT_CFGPROC_STATUS_EN appends a trailing status
// byte {timeout_sticky, cmd_count[6:0]} to every response.
//
// Handshake rule for every stream port: a beat transfers on a rising clock_sig
// edge where valid and ready are both high; valid never depends on ready.
//
// dbg_state encoding: 0 IDLE, 1 ESCAPE, 2 CONFDATA, 3 SENDRESP.
module peridot_config_proc_mb #(
  parameter logic [7:0] CMD_BYTE   = 8'h3A,
  parameter logic [7:0] ESC_BYTE   = 8'h3D,
  parameter logic [7:0] ESC_XOR    = 8'h20,
  parameter int         GPIO_BYTES = 1,
  parameter int         TIMEOUT    = 65535
) (
  input  logic                    clock_sig,
  input  logic                    reset_sig,
  output logic                    in_ready,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [7:0]              out_data,
  output logic                    pk_ready,
  input  logic                    pk_valid,
  input  logic [7:0]              pk_data,
  input  logic                    resp_ready,
  output logic                    resp_valid,
  output logic [7:0]              resp_data,
  output logic                    reset_request,
  output logic                    ft_si,
  output logic                    i2c_scl_o,
  input  logic                    i2c_scl_i,
  output logic                    i2c_sda_o,
  input  logic                    i2c_sda_i,
  input  logic                    ru_bootsel,
  output logic                    ru_nconfig,
  input  logic                    ru_nstatus,
  output logic [8*GPIO_BYTES-1:0] gpio_o,
  input  logic [8*GPIO_BYTES-1:0] gpio_i,
  output logic [1:0]              dbg_state
);

`ifdef PERIDOT_CFGPROC_STATUS_EN
  localparam int STAT_N = 1;
`else
  localparam int STAT_N = 0;
`endif
  localparam int         GW       = 8 * GPIO_BYTES;
  localparam int         RW       = 8 * (GPIO_BYTES + 1 + STAT_N);
  localparam logic [2:0] LAST_CFG = 3'(GPIO_BYTES);
  localparam logic [2:0] LAST_RSP = 3'(GPIO_BYTES + STAT_N);
  localparam logic [15:0] TMAX    = 16'(TIMEOUT);

  typedef enum logic [1:0] {IDLE = 2'd0, ESCAPE = 2'd1, CONFDATA = 2'd2, SENDRESP = 2'd3} state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [15:0]   tmr_q, tmr_d;
  logic [GW-1:0] shadow_q, shadow_d;
  logic          mode_q, mode_d;
  logic          nconfig_q, nconfig_d;
  logic          ft_q, ft_d;
  logic          scl_q, scl_d;
  logic          sda_q, sda_d;
  logic [GW-1:0] gpio_q, gpio_d;
  logic          bootsel_s_q, bootsel_s_d;
  logic          nstatus_s_q, nstatus_s_d;
  logic          scl_s_q, scl_s_d;
  logic          sda_s_q, sda_s_d;
  logic [GW-1:0] gpio_s_q, gpio_s_d;
`ifdef PERIDOT_CFGPROC_STATUS_EN
  logic [6:0]    cnt_q, cnt_d;
  logic          sticky_q, sticky_d;
`endif

  logic           out_ready_eff;
  logic [GW+7:0]  cfg_vec;
  logic [7:0]     resp_b0;
  logic [RW-1:0]  resp_vec;

  // Full command image: buffered bytes plus the byte arriving on the commit beat.
  assign cfg_vec = {in_data, shadow_q};
  assign resp_b0 = {2'b00, sda_s_q, scl_s_q, 1'b0, nstatus_s_q, nstatus_s_q, bootsel_s_q};
`ifdef PERIDOT_CFGPROC_STATUS_EN
  assign resp_vec = {sticky_q, cnt_q, gpio_s_q, resp_b0};
`else
  assign resp_vec = {gpio_s_q, resp_b0};
`endif

  assign out_ready_eff = mode_q ? out_ready : 1'b1;
  assign ru_nconfig    = mode_q ? 1'b1 : nconfig_q;
  assign reset_request = ~mode_q;
  assign ft_si         = ft_q;
  assign i2c_scl_o     = scl_q;
  assign i2c_sda_o     = sda_q;
  assign gpio_o        = gpio_q;
  assign dbg_state     = state_q;

  // Next-state and handshake decode for the protocol FSM.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    tmr_d       = tmr_q;
    shadow_d    = shadow_q;
    mode_d      = mode_q;
    nconfig_d   = nconfig_q;
    ft_d        = ft_q;
    scl_d       = scl_q;
    sda_d       = sda_q;
    gpio_d      = gpio_q;
    bootsel_s_d = bootsel_s_q;
    nstatus_s_d = nstatus_s_q;
    scl_s_d     = scl_s_q;
    sda_s_d     = sda_s_q;
    gpio_s_d    = gpio_s_q;
`ifdef PERIDOT_CFGPROC_STATUS_EN
    cnt_d       = cnt_q;
    sticky_d    = sticky_q;
`endif
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    out_data    = in_data;
    pk_ready    = resp_ready;
    resp_valid  = pk_valid;
    resp_data   = pk_data;
    case (state_q)
      IDLE: begin
        if (in_valid && in_data == CMD_BYTE) begin
          in_ready = 1'b1;
          state_d  = CONFDATA;
          idx_d    = 3'd0;
          tmr_d    = 16'd0;
        end else if (in_valid && in_data == ESC_BYTE) begin
          in_ready = 1'b1;
          state_d  = ESCAPE;
        end else begin
          in_ready  = out_ready_eff;
          out_valid = in_valid & mode_q;
        end
      end
      ESCAPE: begin
        in_ready  = out_ready_eff;
        out_valid = in_valid & mode_q;
        out_data  = in_data ^ ESC_XOR;
        if (in_valid && out_ready_eff) state_d = IDLE;
      end
      CONFDATA: begin
        in_ready   = 1'b1;
        pk_ready   = 1'b0;
        resp_valid = 1'b0;
        resp_data  = 8'h00;
        if (in_valid) begin
          tmr_d = 16'd0;
          if (idx_q == LAST_CFG) begin
            nconfig_d   = cfg_vec[0];
            ft_d        = cfg_vec[1];
            mode_d      = cfg_vec[3];
            scl_d       = cfg_vec[4];
            sda_d       = cfg_vec[5];
            gpio_d      = cfg_vec[GW+7:8];
            bootsel_s_d = ru_bootsel;
            nstatus_s_d = ru_nstatus;
            scl_s_d     = i2c_scl_i;
            sda_s_d     = i2c_sda_i;
            gpio_s_d    = gpio_i;
            idx_d       = 3'd0;
            state_d     = SENDRESP;
`ifdef PERIDOT_CFGPROC_STATUS_EN
            if (cnt_q != 7'h7F) cnt_d = cnt_q + 7'd1;
`endif
          end else begin
            shadow_d[{idx_q, 3'b000} +: 8] = in_data;
            idx_d = idx_q + 3'd1;
          end
        end else if ((TIMEOUT != 0) && (tmr_q == TMAX)) begin
          shadow_d = '0;
          idx_d    = 3'd0;
          tmr_d    = 16'd0;
          state_d  = IDLE;
`ifdef PERIDOT_CFGPROC_STATUS_EN
          sticky_d = 1'b1;
`endif
        end else begin
          tmr_d = tmr_q + 16'd1;
        end
      end
      SENDRESP: begin
        resp_valid = 1'b1;
        pk_ready   = 1'b0;
        resp_data  = resp_vec[{idx_q, 3'b000} +: 8];
        if (resp_ready) begin
          if (idx_q == LAST_RSP) begin
            idx_d   = 3'd0;
            state_d = IDLE;
`ifdef PERIDOT_CFGPROC_STATUS_EN
            cnt_d    = 7'd0;
            sticky_d = 1'b0;
`endif
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, committed configuration and sampled status registers.
  always_ff @(posedge clock_sig or posedge reset_sig) begin
    if (reset_sig) begin
      state_q     <= IDLE;
      idx_q       <= 3'd0;
      tmr_q       <= 16'd0;
      shadow_q    <= '0;
      mode_q      <= 1'b1;
      nconfig_q   <= 1'b1;
      ft_q        <= 1'b0;
      scl_q       <= 1'b1;
      sda_q       <= 1'b1;
      gpio_q      <= '0;
      bootsel_s_q <= 1'b0;
      nstatus_s_q <= 1'b0;
      scl_s_q     <= 1'b1;
      sda_s_q     <= 1'b1;
      gpio_s_q    <= '0;
`ifdef PERIDOT_CFGPROC_STATUS_EN
      cnt_q       <= 7'd0;
      sticky_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      tmr_q       <= tmr_d;
      shadow_q    <= shadow_d;
      mode_q      <= mode_d;
      nconfig_q   <= nconfig_d;
      ft_q        <= ft_d;
      scl_q       <= scl_d;
      sda_q       <= sda_d;
      gpio_q      <= gpio_d;
      bootsel_s_q <= bootsel_s_d;
      nstatus_s_q <= nstatus_s_d;
      scl_s_q     <= scl_s_d;
      sda_s_q     <= sda_s_d;
      gpio_s_q    <= gpio_s_d;
`ifdef PERIDOT_CFGPROC_STATUS_EN
      cnt_q       <= cnt_d;
      sticky_q    <= sticky_d;
`endif
    end
  end

endmodule

// File: tb/tb_peridot_config_proc_mb.sv
// Testbench for peridot_config_proc_mb (GPIO_BYTES=2, TIMEOUT=16, default build).
module tb_peridot_config_proc_mb;
  localparam int G   = 2;
  localparam int TMO = 16;
  localparam logic [7:0] CMD = 8'h3A;
  localparam logic [7:0] ESC = 8'h3D;

  logic           clock_sig = 1'b0;
  logic           reset_sig;
  logic           in_ready, in_valid;
  logic [7:0]     in_data;
  logic           out_ready, out_valid;
  logic [7:0]     out_data;
  logic           pk_ready, pk_valid;
  logic [7:0]     pk_data;
  logic           resp_ready, resp_valid;
  logic [7:0]     resp_data;
  logic           reset_request, ft_si;
  logic           i2c_scl_o, i2c_scl_i, i2c_sda_o, i2c_sda_i;
  logic           ru_bootsel, ru_nconfig, ru_nstatus;
  logic [8*G-1:0] gpio_o, gpio_i;
  logic [1:0]     dbg_state;

  peridot_config_proc_mb #(.GPIO_BYTES(G), .TIMEOUT(TMO)) dut (
    .clock_sig(clock_sig), .reset_sig(reset_sig),
    .in_ready(in_ready), .in_valid(in_valid), .in_data(in_data),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .pk_ready(pk_ready), .pk_valid(pk_valid), .pk_data(pk_data),
    .resp_ready(resp_ready), .resp_valid(resp_valid), .resp_data(resp_data),
    .reset_request(reset_request), .ft_si(ft_si),
    .i2c_scl_o(i2c_scl_o), .i2c_scl_i(i2c_scl_i),
    .i2c_sda_o(i2c_sda_o), .i2c_sda_i(i2c_sda_i),
    .ru_bootsel(ru_bootsel), .ru_nconfig(ru_nconfig), .ru_nstatus(ru_nstatus),
    .gpio_o(gpio_o), .gpio_i(gpio_i), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clock_sig = ~clock_sig;

  int checks = 0;
  int errors = 0;
  logic [7:0] out_exp_q[$];
  logic [7:0] resp_exp_q[$];
  bit or_rand = 1'b0;
  bit rr_rand = 1'b0;

  // reference model of the committed configuration
  logic           m_mode, m_nconfig, m_ft, m_scl, m_sda;
  logic [8*G-1:0] m_gpio;

  task automatic model_reset();
    m_mode = 1'b1; m_nconfig = 1'b1; m_ft = 1'b0; m_scl = 1'b1; m_sda = 1'b1; m_gpio = '0;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_regs(input string name);
    logic [31:0] act, exp;
    act = 32'({reset_request, ru_nconfig, ft_si, i2c_scl_o, i2c_sda_o, gpio_o});
    exp = 32'({~m_mode, (m_mode ? 1'b1 : m_nconfig), m_ft, m_scl, m_sda, m_gpio});
    check(name, act, exp);
  endtask

  // ---------------- background backpressure ----------------
  initial forever begin
    @(negedge clock_sig);
    if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
    if (rr_rand) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // ---------------- scoreboard monitor ----------------
  initial forever begin
    @(negedge clock_sig);
    #2;
    if (!reset_sig && out_valid && out_ready) begin
      if (out_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL out_unexpected: got 0x%02h, expected no beat", out_data);
      end else check("out_data", 32'(out_data), 32'(out_exp_q.pop_front()));
    end
    if (!reset_sig && resp_valid && resp_ready) begin
      if (resp_exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL resp_unexpected: got 0x%02h, expected no beat", resp_data);
      end else check("resp_data", 32'(resp_data), 32'(resp_exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock_sig);
    in_valid = 1'b1; in_data = b;
    #1;
    while (!in_ready && n < 300) begin @(negedge clock_sig); #1; n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL in_handshake: in_ready stuck 0 for byte 0x%02h, required 1", b);
    end
    @(posedge clock_sig);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_pk(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clock_sig);
    pk_valid = 1'b1; pk_data = b;
    #1;
    while (!pk_ready && n < 300) begin @(negedge clock_sig); #1; n++; end
    if (!pk_ready) begin
      checks++; errors++;
      $display("FAIL pk_handshake: pk_ready stuck 0 for byte 0x%02h, required 1", b);
    end
    @(posedge clock_sig);
    #1 pk_valid = 1'b0;
  endtask

  // Full config command: expected response queued, model updated, registers checked.
  task automatic send_cmd(input logic [7:0] b0, input logic [8*G-1:0] gp,
                          input logic [8*G-1:0] gin, input logic bs, input logic ns,
                          input logic scl, input logic sda, input int gap_max);
    ru_bootsel = bs; ru_nstatus = ns; i2c_scl_i = scl; i2c_sda_i = sda; gpio_i = gin;
    resp_exp_q.push_back({2'b00, sda, scl, 1'b0, ns, ns, bs});
    for (int k = 0; k < G; k++) resp_exp_q.push_back(gin[8*k +: 8]);
    send_byte(CMD);
    repeat ($urandom_range(0, gap_max)) @(negedge clock_sig);
    send_byte(b0);
    for (int k = 0; k < G; k++) begin
      repeat ($urandom_range(0, gap_max)) @(negedge clock_sig);
      send_byte(gp[8*k +: 8]);
    end
    m_nconfig = b0[0]; m_ft = b0[1]; m_mode = b0[3]; m_scl = b0[4]; m_sda = b0[5];
    m_gpio = gp;
    check_regs("cmd_commit_regs");
  endtask

  // Partial command followed by a stall longer than the timeout.
  task automatic send_abort(input int nbytes);
    send_byte(CMD);
    for (int k = 0; k < nbytes; k++) send_byte(8'($urandom));
    repeat (TMO + 6) @(negedge clock_sig);
    #2;
    check("abort_state", 32'(dbg_state), 32'd0);
    check_regs("abort_regs");
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((out_exp_q.size() != 0 || resp_exp_q.size() != 0) && n < 2000) begin
      @(negedge clock_sig); n++;
    end
    repeat (2) @(negedge clock_sig);
    check("drain_out_q", 32'(out_exp_q.size()), 32'd0);
    check("drain_resp_q", 32'(resp_exp_q.size()), 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [7:0] b, first;
    int kind;
    int n;
    reset_sig = 1'b1;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    pk_valid = 1'b0; pk_data = 8'h00; resp_ready = 1'b1;
    i2c_scl_i = 1'b1; i2c_sda_i = 1'b1; ru_bootsel = 1'b0; ru_nstatus = 1'b0; gpio_i = '0;
    model_reset();
    repeat (3) @(negedge clock_sig);
    reset_sig = 1'b0;
    #2;
    check_regs("reset_regs");
    check("reset_state", 32'(dbg_state), 32'd0);
    check("reset_valids", 32'({out_valid, resp_valid}), 32'd0);

    // pass-through and stall
    out_exp_q.push_back(8'h41);
    send_byte(8'h41);
    @(negedge clock_sig);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h42;
    #1;
    check("stall_in_ready", 32'(in_ready), 32'd0);
    check("stall_out_valid", 32'(out_valid), 32'd1);
    out_exp_q.push_back(8'h42);
    @(negedge clock_sig);
    out_ready = 1'b1;
    @(posedge clock_sig);
    #1 in_valid = 1'b0;

    // escape
    out_exp_q.push_back(8'h3A);
    send_byte(ESC);
    check("escape_state", 32'(dbg_state), 32'd1);
    send_byte(8'h1A);
    check("escape_back_idle", 32'(dbg_state), 32'd0);
    wait_drain();

    // config commit
    send_cmd(8'h30, 16'h5AA5, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 0);
    check("commit_gpio_o", 32'(gpio_o), 32'h5AA5);
    check("commit_reset_request", 32'(reset_request), 32'd1);
    wait_drain();

    // config-mode discard
    @(negedge clock_sig);
    out_ready = 1'b0; in_valid = 1'b1; in_data = 8'h55;
    #1;
    check("discard_in_ready", 32'(in_ready), 32'd1);
    check("discard_out_valid", 32'(out_valid), 32'd0);
    @(posedge clock_sig);
    #1 in_valid = 1'b0;
    out_ready = 1'b1;

    // back to normal mode, then timeout
    send_cmd(8'h39, 16'hC3E1, 16'h0F0F, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    wait_drain();
    send_byte(CMD);
    send_byte(8'h01);
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_sig); #2;
      if (i == 10) check("timeout_no_resp", 32'(resp_valid), 32'd0);
    end
    check("timeout_state", 32'(dbg_state), 32'd0);
    check_regs("timeout_regs");
    out_exp_q.push_back(8'h41);
    send_byte(8'h41);
    wait_drain();

    // response backpressure with a packet byte waiting
    resp_ready = 1'b0;
    send_cmd(8'h18, 16'h0102, 16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b1, 0);
    first = resp_exp_q[0];
    @(negedge clock_sig);
    pk_valid = 1'b1; pk_data = 8'h77;
    resp_exp_q.push_back(8'h77);
    for (int i = 0; i < 10; i++) begin
      @(negedge clock_sig); #2;
      check("bp_hold", 32'({resp_valid, resp_data, pk_ready}), 32'({1'b1, first, 1'b0}));
    end
    @(negedge clock_sig);
    resp_ready = 1'b1;
    n = 0;
    #1;
    while (!pk_ready && n < 50) begin @(negedge clock_sig); #1; n++; end
    check("bp_pk_ready_after", 32'(pk_ready), 32'd1);
    @(posedge clock_sig);
    #1 pk_valid = 1'b0;
    wait_drain();

    // reset in the middle of a command
    send_byte(CMD);
    send_byte(8'h30);
    @(negedge clock_sig);
    reset_sig = 1'b1;
    model_reset();
    #2;
    check_regs("reset_mid_regs");
    check("reset_mid_state", 32'(dbg_state), 32'd0);
    @(negedge clock_sig);
    reset_sig = 1'b0;

    // randomized traffic
    or_rand = 1'b1;
    rr_rand = 1'b1;
    for (int t = 0; t < 200; t++) begin
      kind = $urandom_range(0, 9);
      if (kind <= 3) begin
        do b = 8'($urandom); while (b == CMD || b == ESC);
        if (m_mode) out_exp_q.push_back(b);
        send_byte(b);
      end else if (kind == 4) begin
        b = 8'($urandom);
        if (m_mode) out_exp_q.push_back(b ^ 8'h20);
        send_byte(ESC);
        send_byte(b);
      end else if (kind <= 6) begin
        b = 8'($urandom);
        b[3] = ($urandom_range(0, 3) != 0);
        send_cmd(b, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 3);
      end else if (kind == 7) begin
        send_abort($urandom_range(0, G));
      end else begin
        b = 8'($urandom);
        resp_exp_q.push_back(b);
        send_pk(b);
      end
    end
    wait_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
